// File: rtl/ram_uart_streamer.sv
// Streams a NUL-terminated string from the 256x8 text RAM out as UART 8N1.
// Reads one byte per frame; stops on NUL or after 256 bytes.
module ram_uart_streamer #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] start_addr,
    output logic       ram_ce,
    output logic       ram_oce,
    output logic       ram_wre,
    output logic [7:0] ram_ad,
    input  logic [7:0] ram_dout,
    output logic       uart_tx,
    output logic       busy,
    output logic       done,
    output logic [8:0] byte_count
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_START,
        S_DATA,
        S_STOP,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [8:0]    count_q, count_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ce_q, ce_d;
    logic          baud_tick;

    assign baud_tick = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = '0;
        count_d = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    count_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                shift_d = ram_dout;
                state_d = (ram_dout == 8'h00) ? S_DONE : S_START;
            end
            S_START: begin
                if (baud_tick) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    count_d = count_q + 9'd1;
                    state_d = S_NEXT;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_NEXT: begin
                if (count_q == 9'd256) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        tx_d = 1'b1;
        if (state_d == S_START) begin
            tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            tx_d = shift_d[0];
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        ce_d   = (state_d == S_FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            count_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            count_q <= count_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ce_q    <= ce_d;
        end
    end

    assign ram_ce     = ce_q;
    assign ram_oce    = 1'b1;
    assign ram_wre    = 1'b0;
    assign ram_ad     = addr_q;
    assign uart_tx    = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_ram_uart_streamer.sv
// Bench for ram_uart_streamer: RAM model, UART frame decoder and
// address monitor feeding queue-based scoreboards.
module tb_ram_uart_streamer;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_addr = 8'h00;
    logic       ram_ce, ram_oce, ram_wre;
    logic [7:0] ram_ad;
    logic [7:0] ram_dout = 8'h00;
    logic       uart_tx, busy, done;
    logic [8:0] byte_count;

    always #5 clk = ~clk;

    ram_uart_streamer #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .start_addr(start_addr),
        .ram_ce(ram_ce),
        .ram_oce(ram_oce),
        .ram_wre(ram_wre),
        .ram_ad(ram_ad),
        .ram_dout(ram_dout),
        .uart_tx(uart_tx),
        .busy(busy),
        .done(done),
        .byte_count(byte_count)
    );

    logic [7:0] mem [256];

    always @(posedge clk)
        if (ram_ce && !ram_wre) ram_dout <= mem[ram_ad];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [7:0] exp_q [$];
    logic [7:0] addr_q [$];

    // Reference: walk RAM from a0 until NUL or 256 bytes sent.
    function automatic int model(input logic [7:0] a0);
        logic [7:0] a;
        int n;
        a = a0;
        n = 0;
        while (n < 256) begin
            addr_q.push_back(a);
            if (mem[a] == 8'h00) break;
            exp_q.push_back(mem[a]);
            n++;
            a = a + 8'd1;
        end
        return n;
    endfunction

    // UART decoder: samples every cycle of a frame on the falling edge.
    bit         mon_act = 0;
    int         mon_s = 0;
    logic [9:0] mon_bits = '0;
    bit         mon_werr = 0;
    int         hi_run = 0;
    int         run_frames = 0;
    int         first_cyc = 0;

    always @(negedge clk) begin
        int b;
        if (!rst_n) begin
            mon_act = 0;
            hi_run = 0;
        end else if (!mon_act) begin
            if (uart_tx === 1'b0) begin
                if (run_frames > 0) check("gap", hi_run, 3);
                if (run_frames == 0) first_cyc = cyc;
                run_frames++;
                mon_act = 1;
                mon_s = 1;
                mon_bits = '0;
                mon_werr = 0;
            end else begin
                hi_run++;
            end
        end else begin
            b = mon_s / CPB;
            if (mon_s % CPB == 0) mon_bits[b] = uart_tx;
            else if (uart_tx !== mon_bits[b]) mon_werr = 1;
            mon_s++;
            if (mon_s == FRAME) begin
                mon_act = 0;
                hi_run = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL frame_extra: got %0h expected none",
                             mon_bits[8:1]);
                end else begin
                    check("frame_byte", mon_bits[8:1], exp_q.pop_front());
                end
                check("frame_fmt", {mon_werr, mon_bits[9]}, 2'b01);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ram_ce) begin
            if (addr_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL addr_extra: got %0h expected none", ram_ad);
            end else begin
                check("ram_ad", ram_ad, addr_q.pop_front());
            end
        end
    end

    int done_cnt = 0;
    int done_cyc = 0;
    always @(negedge clk)
        if (rst_n && done) begin
            done_cnt++;
            done_cyc = cyc;
        end

    task automatic go(input logic [7:0] a, output int n, output int sc);
        @(posedge clk);
        #1;
        n = model(a);
        run_frames = 0;
        done_cnt = 0;
        start = 1'b1;
        start_addr = a;
        sc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_addr = 8'($urandom);
    endtask

    task automatic finish_run(input int n, input int sc, input string tag);
        int budget;
        int k;
        int dexp;
        budget = (n + 2) * (FRAME + 3) + 20;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: got no done expected done", tag);
            return;
        end
        if (n < 256) dexp = sc + 3 + n * (FRAME + 3);
        else dexp = sc + 3 + 255 * (FRAME + 3) + FRAME + 1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_cyc"}, done_cyc, dexp);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_byte_count"}, byte_count, n);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done_low"}, done, 0);
        check({tag, "_frames"}, run_frames, n);
        check({tag, "_exp_left"}, exp_q.size(), 0);
        check({tag, "_addr_left"}, addr_q.size(), 0);
        if (n > 0) check({tag, "_first_cyc"}, first_cyc, sc + 3);
    endtask

    task automatic load_hello();
        logic [7:0] h [13];
        h = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77,
              8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0A, 8'h00};
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
        for (int i = 0; i < 13; i++) mem[i] = h[i];
    endtask

    initial begin
        int n;
        int sc;
        int k;
        logic [7:0] a;
        logic [7:0] idx;

        load_hello();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ce", ram_ce, 0);
        check("rst_ad", ram_ad, 0);
        check("rst_count", byte_count, 0);
        check("rst_oce", ram_oce, 1);
        check("rst_wre", ram_wre, 0);
        rst_n = 1'b1;

        go(8'h00, n, sc);
        finish_run(n, sc, "hello");

        go(8'h0C, n, sc);
        finish_run(n, sc, "nul");

        for (int i = 0; i < 256; i++) mem[i] = 8'h41;
        go(8'hFF, n, sc);
        finish_run(n, sc, "wrap");

        load_hello();
        go(8'h00, n, sc);
        k = 0;
        while (run_frames < 3 && k < 4 * (FRAME + 3)) begin
            @(posedge clk);
            k++;
        end
        check("restart_reach_f3", run_frames >= 3, 1);
        @(posedge clk);
        #1;
        start = 1'b1;
        start_addr = 8'h05;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_run(n, sc, "restart");

        go(8'h00, n, sc);
        k = 0;
        while (run_frames < 2 && k < 3 * (FRAME + 3)) begin
            @(posedge clk);
            k++;
        end
        check("rst_reach_f2", run_frames >= 2, 1);
        repeat (CPB + 2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", uart_tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_ce", ram_ce, 0);
        check("midrst_count", byte_count, 0);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        go(8'h03, n, sc);
        finish_run(n, sc, "after_rst");

        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
            a = 8'($urandom);
            idx = a + 8'($urandom_range(0, 20));
            mem[idx] = 8'h00;
            go(a, n, sc);
            finish_run(n, sc, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
